// File: rtl/seq_axil_regs.sv
// AXI4-Lite register bank for the sequencer: run/stop, stop source, program-memory address/data/write-enable, status readback.
// Latency: write commit 1 cycle after both AW and W are captured, bvalid the cycle after; rdata/rvalid 1 cycle after AR.
// Backpressure: AW/W refused while bvalid is held (bready low); AR refused while rvalid is held (rready low).
module seq_axil_regs #(
    parameter int ADDR_W     = 8,
    parameter int AXI_ADDR_W = 5
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_areset,
    input  logic [AXI_ADDR_W-1:0] s00_axi_awaddr,
    input  logic                  s00_axi_awvalid,
    output logic                  s00_axi_awready,
    input  logic [31:0]           s00_axi_wdata,
    input  logic [3:0]            s00_axi_wstrb,
    input  logic                  s00_axi_wvalid,
    output logic                  s00_axi_wready,
    output logic [1:0]            s00_axi_bresp,
    output logic                  s00_axi_bvalid,
    input  logic                  s00_axi_bready,
    input  logic [AXI_ADDR_W-1:0] s00_axi_araddr,
    input  logic                  s00_axi_arvalid,
    output logic                  s00_axi_arready,
    output logic [31:0]           s00_axi_rdata,
    output logic [1:0]            s00_axi_rresp,
    output logic                  s00_axi_rvalid,
    input  logic                  s00_axi_rready,
    input  logic                  eos_in,
    input  logic [31:0]           mem_rdata,
    output logic                  stop_reg,
    output logic                  stop_src,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [31:0]           mem_din,
    output logic                  mem_we,
    output logic                  mem_we_pulse
);

    logic              awready_q, wready_q, arready_q, bvalid_q, rvalid_q;
    logic              aw_full_q, w_full_q;
    logic [2:0]        aw_idx_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic [31:0]       rdata_q;
    logic              stop_q, wea_q, src_q, pulse_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;

    logic              aw_hs, w_hs, ar_hs, commit, b_free;
    logic              awready_d, wready_d, arready_d, pulse_d;
    logic [31:0]       old_val, wr_val, rd_val;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    function automatic logic [31:0] reg_value(input logic [2:0] idx);
        logic [31:0] v;
        v = '0;
        case (idx)
            3'd0:    v = {31'd0, stop_q};
            3'd1:    v = {31'd0, eos_in};
            3'd2:    v = {31'd0, wea_q};
            3'd3:    v = 32'(addr_q);
            3'd4:    v = data_q;
            3'd6:    v = {31'd0, src_q};
            3'd7:    v = mem_rdata;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

    always_comb begin
        aw_hs     = awready_q & s00_axi_awvalid;
        w_hs      = wready_q & s00_axi_wvalid;
        ar_hs     = arready_q & s00_axi_arvalid;
        commit    = aw_full_q & w_full_q;
        // Re-arming while the B beat is being consumed keeps back-to-back writes at one per 3 cycles.
        b_free    = ~bvalid_q | s00_axi_bready;
        awready_d = s00_axi_awvalid & ~awready_q & ~aw_full_q & b_free;
        wready_d  = s00_axi_wvalid & ~wready_q & ~w_full_q & b_free;
        arready_d = s00_axi_arvalid & ~arready_q & ~rvalid_q;
        old_val   = reg_value(aw_idx_q);
        rd_val    = reg_value(s00_axi_araddr[4:2]);
        wr_val    = byte_merge(old_val, w_data_q, w_strb_q);
        pulse_d   = commit & (aw_idx_q == 3'd2) & w_strb_q[0] & ~wea_q & w_data_q[0];
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            rdata_q   <= '0;
            stop_q    <= 1'b0;
            wea_q     <= 1'b0;
            src_q     <= 1'b0;
            pulse_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            pulse_q   <= pulse_d;

            if (commit) begin
                aw_full_q <= 1'b0;
            end else if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= s00_axi_awaddr[4:2];
            end

            if (commit) begin
                w_full_q <= 1'b0;
            end else if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= s00_axi_wdata;
                w_strb_q <= s00_axi_wstrb;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                case (aw_idx_q)
                    3'd0:    stop_q <= wr_val[0];
                    3'd2:    wea_q  <= wr_val[0];
                    3'd3:    addr_q <= wr_val[ADDR_W-1:0];
                    3'd4:    data_q <= wr_val;
                    3'd6:    src_q  <= wr_val[0];
                    default: ;
                endcase
            end else if (s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
            end else if (s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign stop_reg        = stop_q;
    assign stop_src        = src_q;
    assign mem_addr        = addr_q;
    assign mem_din         = data_q;
    assign mem_we          = wea_q;
    assign mem_we_pulse    = pulse_q;

endmodule

// File: tb/tb_seq_axil_regs.sv
// Bench for seq_axil_regs: vector table, directed channel/reset sequences, randomized traffic against a register-map model.
module tb_seq_axil_regs;
    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0, mem_rdata = '0;
    logic [3:0]  wstrb = '0;
    logic        eos_in = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, mem_din;
    logic        stop_reg, stop_src, mem_we, mem_we_pulse;
    logic [ADDR_W-1:0] mem_addr;

    always #5 clk = ~clk;

    seq_axil_regs #(.ADDR_W(ADDR_W), .AXI_ADDR_W(5)) dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst),
        .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .eos_in(eos_in), .mem_rdata(mem_rdata),
        .stop_reg(stop_reg), .stop_src(stop_src), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .mem_we_pulse(mem_we_pulse)
    );

    int checks = 0, failures = 0;
    int pulse_cnt = 0, b_hs = 0;
    typedef struct packed { logic [7:0] a; logic [31:0] d; } pulse_t;
    pulse_t pulses[$];

    // Register-map model: stored value per index, masked by the bits that index implements.
    logic [31:0] model [8];
    logic [31:0] impl_mask [8] = '{32'h1, 32'h0, 32'h1, 32'hFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0};

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we_pulse) begin
                pulse_cnt++;
                pulses.push_back('{mem_addr, mem_din});
            end
            if (bvalid && bready) b_hs++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT handshake", name);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model[i] = '0;
    endtask

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] bm;
        bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        model[idx] = ((model[idx] & ~bm) | (d & bm)) & impl_mask[idx];
    endtask

    function automatic logic [31:0] exp_read(input int idx);
        if (idx == 1) return {31'd0, eos_in};
        if (idx == 7) return mem_rdata;
        return model[idx];
    endfunction

    task automatic check_outputs();
        check("stop_reg", 32'(stop_reg), 32'(model[0][0]));
        check("stop_src", 32'(stop_src), 32'(model[6][0]));
        check("mem_we", 32'(mem_we), 32'(model[2][0]));
        check("mem_addr", 32'(mem_addr), model[3]);
        check("mem_din", mem_din, model[4]);
    endtask

    task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        bit aw_done, w_done, hs_aw, hs_w, exp_pulse;
        int n, p0;
        p0 = pulse_cnt;
        exp_pulse = (idx == 2) && s[0] && !model[2][0] && d[0];
        awaddr = {3'(idx), 2'b00};
        wdata = d; wstrb = s;
        awvalid = 1; wvalid = 1; bready = 1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 40) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            if (hs_aw) begin awvalid = 0; aw_done = 1; end
            if (hs_w)  begin wvalid = 0; w_done = 1; end
            n++;
        end
        if (!(aw_done && w_done)) begin
            awvalid = 0; wvalid = 0;
            timeout_fail("write_addr_data");
            return;
        end
        n = 0;
        while (!bvalid && n < 40) begin @(posedge clk); #1; n++; end
        if (!bvalid) begin
            timeout_fail("write_resp");
            return;
        end
        check("bresp", 32'(bresp), 32'd0);
        model_write(idx, d, s);
        @(posedge clk); #1;
        check("we_pulse_count", 32'(pulse_cnt - p0), 32'(exp_pulse));
    endtask

    task automatic axi_read(input int idx, input string name);
        logic [31:0] exp;
        int n;
        exp = exp_read(idx);
        araddr = {3'(idx), 2'b00};
        arvalid = 1; rready = 1; n = 0;
        while (!arready && n < 40) begin @(posedge clk); #1; n++; end
        if (!arready) begin
            arvalid = 0;
            timeout_fail(name);
            return;
        end
        @(posedge clk); #1;
        arvalid = 0;
        check({name, "_rvalid"}, 32'(rvalid), 32'd1);
        check(name, rdata, exp);
        check({name, "_rresp"}, 32'(rresp), 32'd0);
        @(posedge clk); #1;
    endtask

    typedef struct { int idx; logic [31:0] d; logic [3:0] s; logic [31:0] exp; } vec_t;
    vec_t tbl[12];
    logic [31:0] prog[10] = '{32'd7, 32'd1248, 32'd724, 32'd1073741828, 32'd537916091,
                              32'd3, 32'd537915547, 32'd3, 32'd1610612740, 32'd2147483648};

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, b0;
        bit w_acc, hold_bad, hs;
        pulse_t p;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        check("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_pulse", 32'(mem_we_pulse), 32'd0);
        check_outputs();
        rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) axi_read(i, $sformatf("reset_read%0d", i));

        tbl[0]  = '{0, 32'h0000_0001, 4'hF, 32'h1};
        tbl[1]  = '{0, 32'hFFFF_FFFE, 4'hF, 32'h0};
        tbl[2]  = '{3, 32'h1234_56AB, 4'hF, 32'hAB};
        tbl[3]  = '{3, 32'hFFFF_FF00, 4'b1110, 32'hAB};
        tbl[4]  = '{4, 32'h0123_4567, 4'hF, 32'h0123_4567};
        tbl[5]  = '{4, 32'hFFFF_FFFF, 4'b0010, 32'h0123_FF67};
        tbl[6]  = '{4, 32'h0000_0000, 4'b0000, 32'h0123_FF67};
        tbl[7]  = '{6, 32'h0000_0003, 4'hF, 32'h1};
        tbl[8]  = '{6, 32'h0000_0000, 4'b0001, 32'h0};
        tbl[9]  = '{1, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[10] = '{5, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[11] = '{2, 32'h0000_0000, 4'hF, 32'h0};
        for (int i = 0; i < 12; i++) begin
            axi_write(tbl[i].idx, tbl[i].d, tbl[i].s);
            araddr = {3'(tbl[i].idx), 2'b00};
            arvalid = 1; rready = 1; n = 0;
            while (!arready && n < 40) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            arvalid = 0;
            check($sformatf("vec%0d", i), rdata, tbl[i].exp);
            @(posedge clk); #1;
        end

        pulses.delete();
        for (int i = 0; i < 10; i++) begin
            axi_write(3, 32'(i), 4'hF);
            axi_write(4, prog[i], 4'hF);
            axi_write(2, 32'h1, 4'hF);
            axi_write(2, 32'h0, 4'hF);
        end
        check("prog_pulse_count", 32'(pulses.size()), 32'd10);
        for (int i = 0; i < 10 && i < pulses.size(); i++) begin
            p = pulses[i];
            check($sformatf("prog_addr%0d", i), 32'(p.a), 32'(i));
            check($sformatf("prog_din%0d", i), p.d, prog[i]);
        end
        check("prog_final_din", mem_din, 32'h8000_0000);
        axi_write(2, 32'h1, 4'hF);
        axi_write(2, 32'h1, 4'hF);
        check_outputs();

        axi_write(0, 32'h1, 4'hF);
        check("stop_set", 32'(stop_reg), 32'd1);
        eos_in = 1;
        axi_read(1, "eos_read");
        axi_write(0, 32'h0, 4'hF);
        check("stop_clr", 32'(stop_reg), 32'd0);
        axi_write(6, 32'h1, 4'hF);
        check("stop_src_set", 32'(stop_src), 32'd1);

        b0 = b_hs;
        awaddr = {3'd4, 2'b00}; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        wvalid = 1; awvalid = 0; bready = 0; w_acc = 0; hold_bad = 0;
        repeat (5) begin
            hs = wvalid && wready;
            if (bvalid) hold_bad = 1;
            @(posedge clk); #1;
            if (hs) begin wvalid = 0; w_acc = 1; end
        end
        check("early_w_accepted", 32'(w_acc), 32'd1);
        check("early_w_no_commit", {31'd0, hold_bad | bvalid}, 32'd0);
        check("early_w_din_held", mem_din, model[4]);
        awvalid = 1; n = 0;
        while (!awready && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        awvalid = 0; n = 0;
        while (!bvalid && n < 40) begin @(posedge clk); #1; n++; end
        check("late_aw_bvalid", 32'(bvalid), 32'd1);
        model_write(4, 32'hDEAD_BEEF, 4'hF);
        awvalid = 1; wvalid = 1;
        repeat (10) begin
            if (!bvalid || awready || wready) hold_bad = 1;
            @(posedge clk); #1;
        end
        check("bready_hold", 32'(hold_bad), 32'd0);
        check("late_aw_din", mem_din, 32'hDEAD_BEEF);
        check("single_commit_b", 32'(b_hs - b0), 32'd0);
        axi_write(4, 32'hDEAD_BEEF, 4'hF);
        check("b_handshakes", 32'(b_hs - b0), 32'd2);

        axi_write(4, 32'h0123_4567, 4'hF);
        axi_write(4, 32'hFFFF_FFFF, 4'b0010);
        axi_read(4, "partial_strobe");
        check("partial_strobe_const", mem_din, 32'h0123_FF67);

        axi_write(1, 32'h0, 4'hF);
        axi_write(5, 32'hFFFF_FFFF, 4'hF);
        for (int i = 0; i < 8; i++) axi_read(i, $sformatf("ro_write_read%0d", i));

        for (int k = 0; k < 300; k++) begin
            eos_in = 1'($urandom);
            mem_rdata = $urandom;
            if ($urandom_range(1, 0) == 1) begin
                axi_write(int'($urandom_range(7, 0)), $urandom, 4'($urandom));
                check_outputs();
            end else begin
                axi_read(int'($urandom_range(7, 0)), "rand_read");
            end
        end

        araddr = {3'd4, 2'b00}; arvalid = 1; rready = 0; n = 0;
        while (!arready && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        arvalid = 0;
        check("pending_rvalid", 32'(rvalid), 32'd1);
        #2 rst = 1;
        #1;
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        check("rst_mid_ready", {29'd0, awready, wready, arready}, 32'd0);
        model_reset();
        check_outputs();
        @(posedge clk); #1;
        rst = 0;
        rready = 1;
        @(posedge clk); #1;
        axi_read(4, "post_rst_data");
        axi_read(0, "post_rst_stop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_axil_regs.md
Name: seq_axil_regs

Overview:
- AXI4-Lite slave (responder) register bank fronting the sequencer core.
- Terminates bus writes and reads issued by the PS or a bench master.
- Exposes control fields (run/stop, stop source, program-memory address, data and write-enable) and returns status (end-of-sequence, memory readback).
- Sits between the AXI interconnect and the sequencer engine; everything is in the s00_axi_aclk domain.

Parameters:
- ADDR_W, 8: program-memory address width in bits; the ADDR register is truncated to this width.
- AXI_ADDR_W, 5: AXI byte-address width; the register index is awaddr/araddr[4:2].

Ports:
- s00_axi_aclk  in  1  single clock
- s00_axi_areset  in  1  asynchronous, active-high reset
- s00_axi_awaddr  in  AXI_ADDR_W  write address
- s00_axi_awvalid / s00_axi_awready  in/out  1  AW handshake
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte strobes
- s00_axi_wvalid / s00_axi_wready  in/out  1  W handshake
- s00_axi_bresp  out  2  always 2'b00
- s00_axi_bvalid / s00_axi_bready  out/in  1  B handshake
- s00_axi_araddr  in  AXI_ADDR_W  read address
- s00_axi_arvalid / s00_axi_arready  in/out  1  AR handshake
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  always 2'b00
- s00_axi_rvalid / s00_axi_rready  out/in  1  R handshake
- eos_in  in  1  end-of-sequence status (already synchronised to s00_axi_aclk)
- mem_rdata  in  32  program-memory readback at mem_addr
- stop_reg  out  1  STOP bit0 (1 = run)
- stop_src  out  1  STOP_SRC bit0 (1 = external stop_sync)
- mem_addr  out  ADDR_W  ADDR register
- mem_din  out  32  DATA register
- mem_we  out  1  WEA bit0 level
- mem_we_pulse  out  1  one-cycle strobe on a WEA 0->1 write

Behaviour:
- Register map (index = addr[4:2]):
  - 0 STOP rw[0]
  - 1 EOS ro[0] = eos_in
  - 2 WEA rw[0]
  - 3 ADDR rw[ADDR_W-1:0]
  - 4 DATA rw[31:0]
  - 5 reserved
  - 6 STOP_SRC rw[0]
  - 7 MEMRD ro = mem_rdata
- Unimplemented bits read 0. Writes to ro/reserved registers are ignored and still complete with OKAY.
- Reset (async assert, sync release): all registers 0; awready = wready = arready = 0; bvalid = rvalid = 0; rdata = 0; mem_we_pulse = 0.
- Write path:
  - AW and W are accepted independently. Each ready is high for one cycle when its skid flag is empty and bvalid = 0.
  - Captured address and data are held in one-entry buffers until both are present.
  - The register update happens on the cycle both buffers are full, byte-masked by wstrb.
  - bvalid asserts the next cycle and holds until bready. No new AW/W is accepted while bvalid = 1.
  - Minimum write throughput is 1 per 3 cycles.
- mem_we_pulse:
  - High for exactly one cycle after a WEA write where old bit0 = 0, new bit0 = 1, and wstrb[0] = 1.
  - Rewriting 1 over 1 produces no pulse.
- Read path:
  - arready pulses when rvalid = 0 and arvalid = 1.
  - rdata is registered from the decoded register; rvalid asserts 1 cycle after the AR handshake and holds with stable rdata until rready.
  - EOS and MEMRD are sampled at the AR handshake cycle.
- Read and write channels are fully concurrent. A read of a register written in the same cycle returns the pre-write value.
- Outputs stop_reg, stop_src, mem_addr, mem_din and mem_we are direct register bits; they change 1 cycle after the write commit.
- Reset asserted mid-transaction: the transaction is aborted, no response is issued, and all handshake outputs drop immediately.

Test Plan:
- Reset, then read every index 0-7 with eos_in = 0 and mem_rdata = 0 -> all rdata = 0, rresp = 0, each rvalid 1 cycle after arready.
- Program-load loop for i = 0..9:
  - writes: ADDR = i, DATA = {7, 1248, 724, 1073741828, 537916091, 3, 537915547, 3, 1610612740, 2147483648}[i], WEA = 1, then WEA = 0.
  - required: exactly 10 mem_we_pulse strobes, each coinciding with mem_addr = i and mem_din = the value for i. The final mem_din is 32'h80000000.
- Write STOP = 1 -> stop_reg = 1. Drive eos_in = 1 and poll EOS -> 1. Write STOP = 0 -> stop_reg = 0. Write STOP_SRC = 1 -> stop_src = 1.
- Channel ordering and back-pressure:
  - W presented 5 cycles before AW (DATA = 32'hDEADBEEF) -> a single commit after AW arrives and one bvalid.
  - bready held low 10 cycles -> bvalid held, awready/wready stay 0.
- Partial strobe: DATA = 32'h01234567, then write 32'hFFFFFFFF with wstrb = 4'b0010 -> read DATA = 32'h0123FF67.
- Write to index 1 (EOS) and index 5 -> bresp OKAY, no register change. Assert s00_axi_areset while rvalid is pending -> rvalid drops immediately and all registers clear.
